commit_watchdog_ctrl: RTL and testbench

//  Simulation-side progress controller for the core's commit stream. Counts committed instructions and cycles,

---
 rtl/sim_monitor_pkg.sv | 24 ++
 rtl/mon_evt_fifo.sv | 50 +++++
 rtl/commit_watchdog_ctrl.sv | 170 +++++++++++++++++
 tb/tb_commit_watchdog_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sim_monitor_pkg.sv
// Shared types for the commit-stream watchdog: event kinds, queued event record, controller states.
package sim_monitor_pkg;

    localparam int MON_CNT_W = 64;

    typedef enum logic [1:0] {
        EVT_PERIODIC   = 2'd0,
        EVT_UART_QUERY = 2'd1,
        EVT_STUCK      = 2'd2
    } evt_kind_e;

    typedef struct packed {
        evt_kind_e              kind;
        logic [MON_CNT_W-1:0]   cycle;
        logic [MON_CNT_W-1:0]   instr;
    } mon_evt_t;

    typedef enum logic [1:0] {
        WD_RUN   = 2'd0,
        WD_DRAIN = 2'd1,
        WD_DONE  = 2'd2
    } wd_state_e;

endpackage

// File: rtl/mon_evt_fifo.sv
// Synchronous event FIFO; a push while full is refused even if a pop happens the same cycle.
module mon_evt_fifo
    import sim_monitor_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = mon_evt_t
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/commit_watchdog_ctrl.sv
// Commit-stream progress watchdog: counts commits/cycles, queues report events, and requests
// end of simulation after a stall has been reported and the event queue has drained.
//
// state    | meaning
// WD_RUN   | normal monitoring, all triggers live
// WD_DRAIN | stall seen; only the STUCK report is still delivered, queue draining
// WD_DONE  | finish_req raised, counters frozen
module commit_watchdog_ctrl
    import sim_monitor_pkg::*;
#(
    parameter int COMMIT_WIDTH  = 6,
    parameter int CNT_W         = MON_CNT_W,
    parameter int STUCK_LIMIT   = 5000,
    parameter int REPORT_PERIOD = 10000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [COMMIT_WIDTH-1:0] commit_valid,
    input  logic                    commit_walk,
    input  logic                    uart_query,
    input  logic                    evt_ready,
    output logic                    evt_valid,
    output logic [1:0]              evt_kind,
    output logic [CNT_W-1:0]        evt_cycle,
    output logic [CNT_W-1:0]        evt_instr,
    output logic [CNT_W-1:0]        dropped,
    output logic                    stuck,
    output logic                    finish_req
);
    localparam int PW = $clog2(REPORT_PERIOD);
    localparam int TW = $clog2(STUCK_LIMIT + 2);
    localparam int I_P = 0;
    localparam int I_U = 1;
    localparam int I_S = 2;

    typedef struct packed {
        evt_kind_e          kind;
        logic [CNT_W-1:0]   cycle;
        logic [CNT_W-1:0]   instr;
    } evt_t;

    wd_state_e          state, state_nxt;
    logic [CNT_W-1:0]   cycle_cnt, commit_cnt, drop_cnt, commit_inc;
    logic [PW-1:0]      period_cnt;
    logic [TW-1:0]      stuck_timer;
    logic [2:0]         pend, trig, acc, drop, sched;
    logic [CNT_W-1:0]   snap_cycle [3];
    logic [CNT_W-1:0]   snap_instr [3];
    evt_kind_e          sel_kind;
    evt_t               push_data, head;
    logic               push, fifo_full, fifo_empty, stuck_q;

    always_comb begin
        commit_inc = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            commit_inc = commit_inc + CNT_W'(commit_valid[i]);
        end
    end

    // Triggers look at registered counters so snapshots show pre-update values.
    always_comb begin
        trig = '0;
        if (state == WD_RUN) begin
            trig[I_P] = (period_cnt == '0);
            trig[I_U] = uart_query;
            trig[I_S] = (stuck_timer > TW'(STUCK_LIMIT));
        end
        acc  = trig & ~pend;
        drop = trig & pend;
    end

    always_comb begin
        sched    = '0;
        sel_kind = EVT_PERIODIC;
        if (!fifo_full) begin
            if (pend[I_S]) begin
                sched[I_S] = 1'b1;
                sel_kind   = EVT_STUCK;
            end else if (pend[I_U]) begin
                sched[I_U] = 1'b1;
                sel_kind   = EVT_UART_QUERY;
            end else if (pend[I_P]) begin
                sched[I_P] = 1'b1;
                sel_kind   = EVT_PERIODIC;
            end
        end
        push            = |sched;
        push_data.kind  = sel_kind;
        push_data.cycle = snap_cycle[sel_kind];
        push_data.instr = snap_instr[sel_kind];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt   <= '0;
            commit_cnt  <= '0;
            period_cnt  <= '0;
            stuck_timer <= '0;
        end else if (state != WD_DONE) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (!commit_walk) commit_cnt <= commit_cnt + commit_inc;
            period_cnt <= (period_cnt == '0) ? PW'(REPORT_PERIOD - 1) : period_cnt - PW'(1);
            if (!commit_walk && commit_valid[0]) begin
                stuck_timer <= '0;
            end else if (stuck_timer != TW'(STUCK_LIMIT + 1)) begin
                stuck_timer <= stuck_timer + TW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend     <= '0;
            drop_cnt <= '0;
            stuck_q  <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                snap_cycle[k] <= '0;
                snap_instr[k] <= '0;
            end
        end else begin
            pend     <= (pend & ~sched) | acc;
            drop_cnt <= drop_cnt + CNT_W'(drop[I_P]) + CNT_W'(drop[I_U]) + CNT_W'(drop[I_S]);
            if (trig[I_S]) stuck_q <= 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (acc[k]) begin
                    snap_cycle[k] <= cycle_cnt;
                    snap_instr[k] <= commit_cnt;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= WD_RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WD_RUN:   if (trig[I_S]) state_nxt = WD_DRAIN;
            WD_DRAIN: if (!pend[I_S] && fifo_empty) state_nxt = WD_DONE;
            default:  state_nxt = WD_DONE;
        endcase
    end

    mon_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (evt_t)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (evt_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid  = !fifo_empty;
    assign evt_kind   = head.kind;
    assign evt_cycle  = head.cycle;
    assign evt_instr  = head.instr;
    assign dropped    = drop_cnt;
    assign stuck      = stuck_q;
    assign finish_req = (state == WD_DONE);

endmodule

// File: tb/tb_commit_watchdog_ctrl.sv
// Directed bench with per-instance event scoreboards; instance A covers reporting, stall and
// finish sequencing, instance B covers a shallow queue under back-pressure.
module tb_commit_watchdog_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  kind;
        logic [63:0] cyc;
        logic [63:0] ins;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    logic        reset_a, walk_a, uq_a, rdy_a, ev_a, stuck_a, fin_a;
    logic [5:0]  cv_a;
    logic [1:0]  kind_a;
    logic [63:0] cyc_a, ins_a, drop_a;

    logic        reset_b, walk_b, uq_b, rdy_b, ev_b, stuck_b, fin_b;
    logic [5:0]  cv_b;
    logic [1:0]  kind_b;
    logic [63:0] cyc_b, ins_b, drop_b;

    commit_watchdog_ctrl #(
        .COMMIT_WIDTH(6), .CNT_W(64), .STUCK_LIMIT(8), .REPORT_PERIOD(16), .FIFO_DEPTH(4)
    ) dut_a (
        .clock(clock), .reset(reset_a), .commit_valid(cv_a), .commit_walk(walk_a),
        .uart_query(uq_a), .evt_ready(rdy_a), .evt_valid(ev_a), .evt_kind(kind_a),
        .evt_cycle(cyc_a), .evt_instr(ins_a), .dropped(drop_a), .stuck(stuck_a),
        .finish_req(fin_a)
    );

    commit_watchdog_ctrl #(
        .COMMIT_WIDTH(6), .CNT_W(64), .STUCK_LIMIT(1000), .REPORT_PERIOD(4), .FIFO_DEPTH(2)
    ) dut_b (
        .clock(clock), .reset(reset_b), .commit_valid(cv_b), .commit_walk(walk_b),
        .uart_query(uq_b), .evt_ready(rdy_b), .evt_valid(ev_b), .evt_kind(kind_b),
        .evt_cycle(cyc_b), .evt_instr(ins_b), .dropped(drop_b), .stuck(stuck_b),
        .finish_req(fin_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    function automatic exp_t mk(input logic [1:0] k, input logic [63:0] c, input logic [63:0] i);
        exp_t e;
        e.kind = k;
        e.cyc  = c;
        e.ins  = i;
        return e;
    endfunction

    // Handshakes are observed on the falling edge, ahead of the rising edge that pops.
    always @(negedge clock) begin
        if (!reset_a && ev_a && rdy_a) begin
            exp_t e;
            checks++;
            assert (q_a.size() != 0) else begin
                errors++;
                $error("FAIL A_unexpected_evt: observed kind=%0d cycle=%0d, expected no event", kind_a, cyc_a);
            end
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                chk("A_evt_kind", 64'(kind_a), 64'(e.kind));
                chk("A_evt_cycle", cyc_a, e.cyc);
                chk("A_evt_instr", ins_a, e.ins);
            end
        end
    end

    always @(negedge clock) begin
        if (!reset_b && ev_b && rdy_b) begin
            exp_t e;
            checks++;
            assert (q_b.size() != 0) else begin
                errors++;
                $error("FAIL B_unexpected_evt: observed kind=%0d cycle=%0d, expected no event", kind_b, cyc_b);
            end
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                chk("B_evt_kind", 64'(kind_b), 64'(e.kind));
                chk("B_evt_cycle", cyc_b, e.cyc);
                chk("B_evt_instr", ins_b, e.ins);
            end
        end
    end

    initial begin
        reset_a = 1'b1; cv_a = 6'b000001; walk_a = 1'b0; uq_a = 1'b0; rdy_a = 1'b1;
        reset_b = 1'b1; cv_b = 6'b000001; walk_b = 1'b0; uq_b = 1'b0; rdy_b = 1'b0;
        tick(2);
        chk("A_rst_evt_valid", 64'(ev_a), 64'd0);
        chk("A_rst_stuck", 64'(stuck_a), 64'd0);
        chk("A_rst_finish", 64'(fin_a), 64'd0);
        chk("A_rst_dropped", drop_a, 64'd0);

        // Periodic reports, UART collision at cycle 16, commit counting with and without walk.
        q_a.push_back(mk(2'd0, 64'd0, 64'd0));
        q_a.push_back(mk(2'd1, 64'd16, 64'd16));
        q_a.push_back(mk(2'd0, 64'd16, 64'd16));
        q_a.push_back(mk(2'd0, 64'd32, 64'd32));
        q_a.push_back(mk(2'd0, 64'd48, 64'd88));
        reset_a = 1'b0;
        tick(16);
        uq_a = 1'b1;
        tick(1);
        uq_a = 1'b0;
        tick(23);
        cv_a = 6'b111111;
        tick(10);
        cv_a = 6'b000001; uq_a = 1'b1;
        q_a.push_back(mk(2'd1, 64'd50, 64'd100));
        tick(1);
        uq_a = 1'b0; cv_a = 6'b111111; walk_a = 1'b1;
        tick(5);
        cv_a = 6'b000000; walk_a = 1'b0; uq_a = 1'b1;
        q_a.push_back(mk(2'd1, 64'd56, 64'd101));
        tick(1);
        uq_a = 1'b0;
        q_a.push_back(mk(2'd2, 64'd60, 64'd101));
        tick(3);
        chk("A_stuck_before_limit", 64'(stuck_a), 64'd0);
        tick(1);
        chk("A_stuck_set", 64'(stuck_a), 64'd1);
        chk("A_finish_while_draining", 64'(fin_a), 64'd0);
        for (int i = 0; i < 20 && !fin_a; i++) tick(1);
        chk("A_finish_req", 64'(fin_a), 64'd1);
        chk("A_dropped", drop_a, 64'd0);
        uq_a = 1'b1;
        tick(3);
        uq_a = 1'b0;
        chk("A_frozen_no_evt", 64'(ev_a), 64'd0);
        chk("A_sb_drained", 64'(q_a.size()), 64'd0);

        // Stall with the queue held, then reset while draining.
        reset_a = 1'b1; rdy_a = 1'b0; cv_a = 6'b000000;
        tick(2);
        reset_a = 1'b0;
        tick(12);
        chk("A_drain_evt_valid", 64'(ev_a), 64'd1);
        chk("A_drain_head_kind", 64'(kind_a), 64'd0);
        chk("A_drain_stuck", 64'(stuck_a), 64'd1);
        chk("A_drain_finish", 64'(fin_a), 64'd0);
        reset_a = 1'b1;
        tick(1);
        chk("A_rst_drain_evt_valid", 64'(ev_a), 64'd0);
        chk("A_rst_drain_stuck", 64'(stuck_a), 64'd0);
        chk("A_rst_drain_finish", 64'(fin_a), 64'd0);
        chk("A_rst_drain_dropped", drop_a, 64'd0);

        // Shallow queue under back-pressure: head must hold while periodic triggers are dropped.
        reset_b = 1'b0;
        tick(2);
        for (int c = 2; c < 18; c++) begin
            chk("B_stall_valid", 64'(ev_b), 64'd1);
            chk("B_stall_kind", 64'(kind_b), 64'd0);
            chk("B_stall_cycle", cyc_b, 64'd0);
            chk("B_stall_instr", ins_b, 64'd0);
            chk("B_dropped_ramp", drop_b, (c >= 17) ? 64'd2 : (c >= 13) ? 64'd1 : 64'd0);
            tick(1);
        end
        q_b.push_back(mk(2'd0, 64'd0, 64'd0));
        q_b.push_back(mk(2'd0, 64'd4, 64'd4));
        q_b.push_back(mk(2'd0, 64'd8, 64'd8));
        q_b.push_back(mk(2'd0, 64'd20, 64'd20));
        rdy_b = 1'b1;
        tick(5);
        rdy_b = 1'b0;
        tick(2);
        chk("B_dropped_final", drop_b, 64'd2);
        chk("B_stuck", 64'(stuck_b), 64'd0);
        chk("B_sb_drained", 64'(q_b.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
